// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// default memory size and datapath widths.
package lsu_pkg;

  localparam int LSU_MEM_BYTES = 256;
  localparam int LSU_ADDR_W    = 16;
  localparam int LSU_DATA_W    = 16;
  localparam int LSU_BYTE_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    WRITE,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane datapath for the load/store unit (purely combinational).
// Produces the load result (word, or low byte sign/zero extended) and the
// read-modify-write word for a byte store (keeps the high byte read back
// from memory, replaces the low byte with the store data).
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [LSU_DATA_W-1:0] i_rdata,
  input  logic                  i_byte,
  input  logic                  i_signed,
  input  logic [LSU_BYTE_W-1:0] i_wdata_lo,
  output logic [LSU_DATA_W-1:0] o_load_data,
  output logic [LSU_DATA_W-1:0] o_merged
);

  logic w_ext_bit;

  // Extension bit is the byte's sign only for signed byte loads.
  assign w_ext_bit   = i_signed & i_rdata[LSU_BYTE_W-1];
  assign o_load_data = i_byte ? {{(LSU_DATA_W-LSU_BYTE_W){w_ext_bit}}, i_rdata[LSU_BYTE_W-1:0]}
                              : i_rdata;
  assign o_merged    = {i_rdata[LSU_DATA_W-1:LSU_BYTE_W], i_wdata_lo};

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts CPU load/store requests over valid/ready and
// sequences a registered-read, 2-byte-write data memory. Byte stores are done
// as read-modify-write; byte loads are sign or zero extended.
// Build option: define LSU_ALIGN_CHECK_EN to reject word accesses at odd
// addresses with an error response instead of passing them to memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = LSU_MEM_BYTES,
  parameter int ADDR_W    = LSU_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic                  req_byte,
  input  logic                  req_signed,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [LSU_DATA_W-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [LSU_DATA_W-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_en,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [LSU_DATA_W-1:0] mem_wdata,
  input  logic [LSU_DATA_W-1:0] mem_rdata
);

  lsu_state_t            r_state;
  logic [ADDR_W-1:0]     r_addr;
  logic [LSU_DATA_W-1:0] r_wdata;
  logic                  r_wr;
  logic                  r_byte;
  logic                  r_signed;
  logic [LSU_DATA_W-1:0] r_rdata;
  logic                  r_err;
  logic [LSU_DATA_W-1:0] r_merged;

  logic                  w_out_of_range;
  logic                  w_misaligned;
  logic                  w_reject;
  logic                  w_issue;
  logic                  w_write;
  logic                  w_word_store;
  logic [LSU_DATA_W-1:0] w_load_data;
  logic [LSU_DATA_W-1:0] w_merged;

  // Every access touches addr and addr+1, so the last legal address is MEM_BYTES-2.
  assign w_out_of_range = (req_addr > ADDR_W'(MEM_BYTES - 2));
`ifdef LSU_ALIGN_CHECK_EN
  assign w_misaligned   = ~req_byte & req_addr[0];
`else
  assign w_misaligned   = 1'b0;
`endif
  assign w_reject       = w_out_of_range | w_misaligned;

  lsu_byte_lane u_byte_lane (
    .i_rdata     (mem_rdata),
    .i_byte      (r_byte),
    .i_signed    (r_signed),
    .i_wdata_lo  (r_wdata[LSU_BYTE_W-1:0]),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  // Request sequencer: latch on accept, walk ISSUE/CAPTURE/WRITE as needed, respond once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wr     <= 1'b0;
      r_byte   <= 1'b0;
      r_signed <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_merged <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_wr     <= req_wr;
            r_byte   <= req_byte;
            r_signed <= req_signed;
            r_rdata  <= '0;
            r_err    <= w_reject;
            r_state  <= w_reject ? RESP : ISSUE;
          end
        end
        ISSUE: begin
          r_state <= (r_wr & ~r_byte) ? RESP : CAPTURE;
        end
        CAPTURE: begin
          if (r_wr) begin
            r_merged <= w_merged;
            r_state  <= WRITE;
          end else begin
            r_rdata  <= w_load_data;
            r_state  <= RESP;
          end
        end
        WRITE: begin
          r_state <= RESP;
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Memory strobes and handshake outputs are pure decodes of the current state.
  assign w_issue      = (r_state == ISSUE);
  assign w_write      = (r_state == WRITE);
  assign w_word_store = r_wr & ~r_byte;

  assign mem_en     = w_issue | w_write;
  assign mem_rd     = w_issue & ~w_word_store;
  assign mem_wr     = (w_issue & w_word_store) | w_write;
  assign mem_addr   = mem_en ? r_addr : '0;
  assign mem_wdata  = (w_issue & w_word_store) ? r_wdata :
                      w_write                  ? r_merged : '0;

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = resp_valid ? r_rdata : '0;
  assign resp_err   = resp_valid & r_err;

endmodule
